// File: rtl/muldiv_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_iter_pkg;

    localparam logic [2:0] MD_OP_MULT  = 3'b000;
    localparam logic [2:0] MD_OP_MULTU = 3'b001;
    localparam logic [2:0] MD_OP_DIV   = 3'b010;
    localparam logic [2:0] MD_OP_DIVU  = 3'b011;
    localparam logic [2:0] MD_OP_MADD  = 3'b100;
    localparam logic [2:0] MD_OP_MADDU = 3'b101;
    localparam logic [2:0] MD_OP_MSUB  = 3'b110;
    localparam logic [2:0] MD_OP_MSUBU = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_ACC  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
module muldiv_iter_step #(
    parameter int DATA_W = 32
) (
    input  logic                  is_div,
    input  logic [2*DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]     opnd,
    output logic [2*DATA_W-1:0]   acc_nxt
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // Mul keeps the multiplier in the low half and retires one bit per step;
    // div keeps the remainder high and shifts quotient bits into the low half.
    always_comb begin
        sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        diff = acc[2*DATA_W-1:DATA_W-1] - {1'b0, opnd};
        if (is_div) begin
            acc_nxt = diff[DATA_W] ? {acc[2*DATA_W-2:0], 1'b0}
                                   : {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
        end else begin
            acc_nxt = {sum, acc[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit with start/ready/annul handshake.
// Optional multiply-accumulate (MADD/MSUB) enabled by defining MULDIV_ACC_EN.
import muldiv_iter_pkg::*;

module muldiv_iter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic [DATA_W-1:0]     hi_i,
    input  logic [DATA_W-1:0]     lo_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [2*DATA_W-1:0]   result_o
);

    md_state_e             state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [2*DATA_W-1:0]   acc, acc_nxt, acc_sum;
    logic [DATA_W-1:0]     opnd;
    logic                  div_r, accum_r, neg_q, neg_r;
    logic                  is_div, is_acc, is_sgn, accept, div0, last;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? -v : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] fixup(input logic [2*DATA_W-1:0] raw,
                                                  input logic div, input logic nq,
                                                  input logic nr);
        logic [DATA_W-1:0] hi, lo;
        if (div) begin
            hi = nr ? -raw[2*DATA_W-1:DATA_W] : raw[2*DATA_W-1:DATA_W];
            lo = nq ? -raw[DATA_W-1:0] : raw[DATA_W-1:0];
            return {hi, lo};
        end
        return nq ? -raw : raw;
    endfunction

    assign is_sgn = ~op_i[0];
`ifdef MULDIV_ACC_EN
    logic [2*DATA_W-1:0] hilo;
    logic                sub_r;

    assign is_acc = op_i[2];
    assign is_div = op_i[1] & ~op_i[2];
    assign acc_sum = sub_r ? hilo - fixup(acc, 1'b0, neg_q, 1'b0)
                           : hilo + fixup(acc, 1'b0, neg_q, 1'b0);

    always_ff @(posedge clk) begin
        if (accept) begin
            hilo  <= {hi_i, lo_i};
            sub_r <= op_i[1];
        end
    end
`else
    logic unused_acc_in;

    assign unused_acc_in = ^{hi_i, lo_i, op_i[2]};
    assign is_acc  = 1'b0;
    assign is_div  = op_i[1];
    assign acc_sum = acc;
`endif

    assign accept  = (state == MD_IDLE) && start_i && !annul_i;
    assign div0    = is_div && (opdata2_i == '0);
    assign last    = (cnt == CNT_W'(DATA_W - 1));
    assign busy_o  = (state != MD_IDLE);
    assign ready_o = (state == MD_DONE);

    muldiv_iter_step #(.DATA_W(DATA_W)) u_step (
        .is_div  (div_r),
        .acc     (acc),
        .opnd    (opnd),
        .acc_nxt (acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= MD_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (accept) state_nxt = div0 ? MD_DONE : MD_BUSY;
            MD_BUSY: begin
                if (annul_i)   state_nxt = MD_IDLE;
                else if (last) state_nxt = accum_r ? MD_ACC : MD_DONE;
            end
            MD_ACC:  state_nxt = annul_i ? MD_IDLE : MD_DONE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // Counter and architecturally visible result
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            result_o <= '0;
        end else begin
            if (accept)                cnt <= '0;
            else if (state == MD_BUSY) cnt <= cnt + 1'b1;

            if (accept && div0)
                result_o <= {opdata1_i, {DATA_W{1'b1}}};
            else if (state == MD_BUSY && last && !annul_i && !accum_r)
                result_o <= fixup(acc_nxt, div_r, neg_q, neg_r);
            else if (state == MD_ACC && !annul_i)
                result_o <= acc_sum;
        end
    end

    // Operand magnitudes and sign fix-up flags, captured at accept
    always_ff @(posedge clk) begin
        if (accept) begin
            acc     <= {{DATA_W{1'b0}}, mag(opdata1_i, is_sgn)};
            opnd    <= mag(opdata2_i, is_sgn);
            div_r   <= is_div;
            accum_r <= is_acc;
            neg_q   <= is_sgn & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r   <= is_sgn & opdata1_i[DATA_W-1];
        end else if (state == MD_BUSY) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter (DATA_W=32); MADDU expectation follows MULDIV_ACC_EN.
import muldiv_iter_pkg::*;

module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, annul_i;
    logic [2:0]  op_i;
    logic [31:0] opdata1_i, opdata2_i, hi_i, lo_i;
    logic        busy_o, ready_o;
    logic [63:0] result_o;

    int n_chk  = 0;
    int n_fail = 0;

    muldiv_iter #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .op_i      (op_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .hi_i      (hi_i),
        .lo_i      (lo_i),
        .busy_o    (busy_o),
        .ready_o   (ready_o),
        .result_o  (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after a rising edge with the unit idle; returns cycles from accept to ready.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo,
                          output int lat, output logic [63:0] res);
        op_i = op; opdata1_i = a; opdata2_i = b; hi_i = hi; lo_i = lo;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        lat = 1;
        while (!ready_o && lat < 100) begin
            tick();
            lat++;
        end
        res = result_o;
        tick();
    endtask

    int          lat;
    int          seen;
    logic [63:0] res;
    logic [63:0] prior;

    initial begin
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
        opdata1_i = '0; opdata2_i = '0; hi_i = '0; lo_i = '0;
        repeat (3) tick();
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b1;
        tick();

        run_op(MD_OP_MULT, 32'hFFFF_FFFE, 32'h3, 0, 0, lat, res);
        check("mult_lat", 64'(lat), 64'd33);
        check("mult_res", res, 64'hFFFF_FFFF_FFFF_FFFA);

        run_op(MD_OP_DIV, 32'hFFFF_FFF9, 32'h2, 0, 0, lat, res);
        check("div_lat", 64'(lat), 64'd33);
        check("div_res", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        run_op(MD_OP_DIVU, 32'hFFFF_FFF9, 32'h2, 0, 0, lat, res);
        check("divu_res", res, {32'h1, 32'h7FFF_FFFC});

        run_op(MD_OP_DIVU, 32'h1234, 32'h0, 0, 0, lat, res);
        check("div0_lat", 64'(lat), 64'd1);
        check("div0_res", res, {32'h1234, 32'hFFFF_FFFF});

        run_op(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, res);
        check("div_ovf_res", res, {32'h0, 32'h8000_0000});

        run_op(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, lat, res);
        check("multu_max_res", res, 64'hFFFF_FFFE_0000_0001);

        run_op(MD_OP_DIV, 32'h7, 32'hFFFF_FFFE, 0, 0, lat, res);
        check("div_pos_neg_res", res, {32'h1, 32'hFFFF_FFFD});
        prior = 64'h0000_0001_FFFF_FFFD;

        // Annul in the middle of a MULTU
        op_i = MD_OP_MULTU; opdata1_i = 32'd9; opdata2_i = 32'd9; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        check("annul_busy", 64'(busy_o), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) seen++;
            tick();
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        check("annul_result_kept", result_o, prior);

        // start and annul together in IDLE
        op_i = MD_OP_MULTU; start_i = 1'b1; annul_i = 1'b1;
        tick();
        start_i = 1'b0; annul_i = 1'b0;
        check("idle_annul_busy", 64'(busy_o), 64'd0);
        check("idle_annul_ready", 64'(ready_o), 64'd0);

        // A second start while busy must be ignored
        op_i = MD_OP_MULTU; opdata1_i = 32'd5; opdata2_i = 32'd5; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (2) tick();
        op_i = MD_OP_DIVU; opdata2_i = 32'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        lat = 4;
        while (!ready_o && lat < 100) begin
            tick();
            lat++;
        end
        check("ignore_lat", 64'(lat), 64'd33);
        check("ignore_res", result_o, 64'd25);
        tick();

        // Reset in the middle of a DIV
        op_i = MD_OP_DIV; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);

        run_op(MD_OP_MULTU, 32'd7, 32'd6, 0, 0, lat, res);
        check("multu76_lat", 64'(lat), 64'd33);
        check("multu76_res", res, 64'd42);

        run_op(MD_OP_MADDU, 32'd2, 32'd3, 32'h0, 32'hFFFF_FFFF, lat, res);
`ifdef MULDIV_ACC_EN
        check("maddu_lat", 64'(lat), 64'd34);
        check("maddu_res", res, 64'h1_0000_0005);
`else
        check("maddu_lat", 64'(lat), 64'd33);
        check("maddu_res", res, 64'd6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
